pcs_pma_10g_drp_arb: RTL

Parametrised N-channel DRP request/grant arbiter for 10G PCS/PMA cores that share one QPLL common block and its single DRP port. Replaces the per-core req→gnt loopback with round-robin arbitration, registered mux of each granted channel's DRP transaction onto the shared port, and gating of grants on shared-PLL readiness. An optional watchdog completes DRP accesses that the shared port never acknowledges. Sits between the per-channel `ten_gig_eth_pcs_pma` DRP master ports and the QPLL common DRP slave, in the `coreclk` (156.25 MHz) domain.

---
 rtl/pcs_pma_10g_drp_arb_pkg.sv | 20 ++
 rtl/pcs_pma_10g_drp_arb_if.sv | 42 ++++
 rtl/pcs_pma_10g_drp_arb_rr_pick.sv | 33 +++
 rtl/pcs_pma_10g_drp_arb.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/pcs_pma_10g_drp_arb_pkg.sv
// Shared types and constants for the PCS/PMA DRP arbiter slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pcs_pma_pkg;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT  = 2'd1,
        ST_ACCESS = 2'd2
    } arb_state_t;

    // Default DRP widths of the QPLL common block.
    localparam int DRP_ADDR_W = 16;
    localparam int DRP_DATA_W = 16;

    // Read data returned to a channel whose access was abandoned by the watchdog.
    localparam logic [DRP_DATA_W-1:0] DRP_TIMEOUT_DATA = '1;

endpackage

// File: rtl/pcs_pma_10g_drp_arb_if.sv
// Bundle of per-channel DRP master ports plus the shared QPLL common DRP port.
// Latency: n/a (wiring only).
// Backpressure: req/gnt handshake per channel; shared port completes on drp_drdy.
interface pcs_pma_10g_drp_arb_if #(
    parameter int NUM_CH = 4,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    // Channel side
    logic [NUM_CH-1:0]        ch_drp_req;
    logic [NUM_CH-1:0]        ch_drp_gnt;
    logic [NUM_CH-1:0]        ch_drp_den;
    logic [NUM_CH-1:0]        ch_drp_dwe;
    logic [NUM_CH*ADDR_W-1:0] ch_drp_daddr;
    logic [NUM_CH*DATA_W-1:0] ch_drp_di;
    logic [NUM_CH-1:0]        ch_drp_drdy;
    logic [DATA_W-1:0]        ch_drp_drpdo;
    // Shared port side
    logic                     drp_den;
    logic                     drp_dwe;
    logic [ADDR_W-1:0]        drp_daddr;
    logic [DATA_W-1:0]        drp_di;
    logic                     drp_drdy;
    logic [DATA_W-1:0]        drp_drpdo;

    // Arbiter view: drives grants, completions and the shared port.
    modport master (
        input  ch_drp_req, ch_drp_den, ch_drp_dwe, ch_drp_daddr, ch_drp_di,
        input  drp_drdy, drp_drpdo,
        output ch_drp_gnt, ch_drp_drdy, ch_drp_drpdo,
        output drp_den, drp_dwe, drp_daddr, drp_di
    );

    // Surrounding view: channels and the QPLL common DRP slave.
    modport slave (
        output ch_drp_req, ch_drp_den, ch_drp_dwe, ch_drp_daddr, ch_drp_di,
        output drp_drdy, drp_drpdo,
        input  ch_drp_gnt, ch_drp_drdy, ch_drp_drpdo,
        input  drp_den, drp_dwe, drp_daddr, drp_di
    );

endinterface

// File: rtl/pcs_pma_10g_drp_arb_rr_pick.sv
// Round-robin picker: first set request strictly after 'last', wrapping modulo NUM_CH.
// Latency: combinational.
// Backpressure: none; vld low when no request is set.
module pcs_pma_rr_pick #(
    parameter int NUM_CH = 4,
    parameter int IW     = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IW-1:0]     last,
    output logic [NUM_CH-1:0] onehot,
    output logic [IW-1:0]     idx,
    output logic              vld
);

    logic [IW-1:0] cand;

    // Scan last+1 .. last+NUM_CH and keep the first requester found.
    always_comb begin
        onehot = '0;
        idx    = '0;
        vld    = 1'b0;
        cand   = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            cand = IW'((int'(last) + i) % NUM_CH);
            if (!vld && req[cand]) begin
                vld          = 1'b1;
                idx          = cand;
                onehot[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pcs_pma_10g_drp_arb.sv
// N-channel DRP arbiter onto one QPLL common DRP port; optional watchdog via PCS_PMA_DRP_TIMEOUT_EN.
// Latency: req->gnt 1 cycle, den->drp_den 1 cycle, drp_drdy->ch_drp_drdy 1 cycle.
// Backpressure: grants gated on ready; one access in flight, grant held until it completes.
module pcs_pma_10g_drp_arb
    import pcs_pma_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int ADDR_W  = DRP_ADDR_W,
    parameter int DATA_W  = DRP_DATA_W,
    parameter int TIMEOUT = 255
) (
    input  logic                      coreclk,
    input  logic                      rst_n,
    input  logic                      ready,
    pcs_pma_10g_drp_arb_if.master     drp_if,
    output logic                      busy,
    output logic                      timeout_err,
    output logic [$clog2(NUM_CH)-1:0] err_ch
);

    localparam int IW = $clog2(NUM_CH);

    if (NUM_CH < 2 || NUM_CH > 16) begin : g_bad_num_ch
        $error("NUM_CH must be in 2..16");
    end
    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("TIMEOUT must be in 1..65535");
    end

    arb_state_t        state_q, state_d;
    logic [IW-1:0]     last_q, last_d;
    logic [IW-1:0]     gidx_q, gidx_d;
    logic [NUM_CH-1:0] gnt_q, gnt_d;
    logic              den_q, den_d;
    logic              dwe_q, dwe_d;
    logic [ADDR_W-1:0] daddr_q, daddr_d;
    logic [DATA_W-1:0] di_q, di_d;
    logic [NUM_CH-1:0] cdrdy_q, cdrdy_d;
    logic [DATA_W-1:0] cdo_q, cdo_d;

    logic [NUM_CH-1:0] pick_oh;
    logic [IW-1:0]     pick_idx;
    logic              pick_vld;

    logic [ADDR_W-1:0] ch_daddr [NUM_CH];
    logic [DATA_W-1:0] ch_di    [NUM_CH];

    for (genvar k = 0; k < NUM_CH; k++) begin : g_unpack
        assign ch_daddr[k] = drp_if.ch_drp_daddr[k*ADDR_W +: ADDR_W];
        assign ch_di[k]    = drp_if.ch_drp_di[k*DATA_W +: DATA_W];
    end

    pcs_pma_rr_pick #(.NUM_CH(NUM_CH), .IW(IW)) u_pick (
        .req    (drp_if.ch_drp_req),
        .last   (last_q),
        .onehot (pick_oh),
        .idx    (pick_idx),
        .vld    (pick_vld)
    );

`ifdef PCS_PMA_DRP_TIMEOUT_EN
    logic [15:0]   cnt_q, cnt_d;
    logic          terr_q, terr_d;
    logic [IW-1:0] errch_q, errch_d;
`endif

    // Next-state and next-output logic; grant is frozen while in ACCESS.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        gidx_d  = gidx_q;
        gnt_d   = gnt_q;
        den_d   = 1'b0;
        dwe_d   = dwe_q;
        daddr_d = daddr_q;
        di_d    = di_q;
        cdrdy_d = '0;
        cdo_d   = cdo_q;
`ifdef PCS_PMA_DRP_TIMEOUT_EN
        cnt_d   = cnt_q;
        terr_d  = 1'b0;
        errch_d = errch_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (ready && pick_vld) begin
                    gnt_d   = pick_oh;
                    gidx_d  = pick_idx;
                    last_d  = pick_idx;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // Request drop or PLL loss beats a same-cycle den.
                if (!drp_if.ch_drp_req[gidx_q] || !ready) begin
                    gnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (drp_if.ch_drp_den[gidx_q]) begin
                    dwe_d   = drp_if.ch_drp_dwe[gidx_q];
                    daddr_d = ch_daddr[gidx_q];
                    di_d    = ch_di[gidx_q];
                    den_d   = 1'b1;
                    state_d = ST_ACCESS;
`ifdef PCS_PMA_DRP_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            ST_ACCESS: begin
                if (drp_if.drp_drdy) begin
                    cdrdy_d = gnt_q;
                    cdo_d   = drp_if.drp_drpdo;
                    state_d = ST_GRANT;
                end
`ifdef PCS_PMA_DRP_TIMEOUT_EN
                else if (cnt_q == 16'(TIMEOUT - 1)) begin
                    cdrdy_d = gnt_q;
                    cdo_d   = '1;
                    terr_d  = 1'b1;
                    errch_d = gidx_q;
                    state_d = ST_GRANT;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
`endif
            end
            default: begin
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge coreclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            last_q  <= IW'(NUM_CH - 1);
            gidx_q  <= '0;
            gnt_q   <= '0;
            den_q   <= 1'b0;
            dwe_q   <= 1'b0;
            daddr_q <= '0;
            di_q    <= '0;
            cdrdy_q <= '0;
            cdo_q   <= '0;
`ifdef PCS_PMA_DRP_TIMEOUT_EN
            cnt_q   <= '0;
            terr_q  <= 1'b0;
            errch_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gidx_q  <= gidx_d;
            gnt_q   <= gnt_d;
            den_q   <= den_d;
            dwe_q   <= dwe_d;
            daddr_q <= daddr_d;
            di_q    <= di_d;
            cdrdy_q <= cdrdy_d;
            cdo_q   <= cdo_d;
`ifdef PCS_PMA_DRP_TIMEOUT_EN
            cnt_q   <= cnt_d;
            terr_q  <= terr_d;
            errch_q <= errch_d;
`endif
        end
    end

    assign drp_if.ch_drp_gnt   = gnt_q;
    assign drp_if.ch_drp_drdy  = cdrdy_q;
    assign drp_if.ch_drp_drpdo = cdo_q;
    assign drp_if.drp_den      = den_q;
    assign drp_if.drp_dwe      = dwe_q;
    assign drp_if.drp_daddr    = daddr_q;
    assign drp_if.drp_di       = di_q;
    assign busy                = (state_q != ST_IDLE);

`ifdef PCS_PMA_DRP_TIMEOUT_EN
    assign timeout_err = terr_q;
    assign err_ch      = errch_q;
`else
    assign timeout_err = 1'b0;
    assign err_ch      = '0;
`endif

endmodule
